tm1640_writer: RTL and testbench
================================

# tm1640_writer

Serial write engine that drives a TM1640-style two-wire LED-matrix controller (clock line plus data line, no acknowledge). It accepts one command byte or one address/data pair per handshake, frames it with bus start/stop conditions and shifts it out LSB first at a divided bit rate. It sits between the display sequencer and the PMOD pins, with its two outputs routed to PMOD bits 6 and 7.

## Interface
- CLK_DIV, 12: system clocks per half-bit tick; legal range 1..65535 (12 MHz clock gives a 1 MHz tick and a 500 kHz bus clock).
- CMD_ONLY_POS, 8'hFF: `pos` value that selects a command-only frame.
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- valid  input  1  request strobe, sampled on the rising edge of CLK.
- pos  input  8  grid address byte (e.g. 8'hC0 + column), or CMD_ONLY_POS.
- value  input  8  data byte, or the command byte when `pos` equals CMD_ONLY_POS.
- o_sclk  output  1  bus clock, driven to PMOD bit 6.
- o_din  output  1  bus data, driven to PMOD bit 7.
- busy  output  1  high while a frame is in progress.

## Operation
- Reset values: o_sclk=1, o_din=1, busy=0, FSM in IDLE. Reset asserted mid-frame aborts the frame and both lines go high immediately.
- Accept: in IDLE with busy=0, a rising edge of CLK that samples valid=1 latches pos and value. valid is ignored at all other times; no queueing.
- Frame type: pos==CMD_ONLY_POS sends a 1-byte frame {value}. Any other pos sends a 2-byte frame {pos, value}.
- FSM states: IDLE -> START -> BITLO/BITHI (loop over 8 bits per byte, all bytes) -> STOP0 -> STOP1 -> STOP2 -> IDLE.
- START: o_din=0 while o_sclk=1.
- BITLO: o_sclk=0, o_din=current bit, LSB first.
- BITHI: o_sclk=1; the slave samples the bit on this rising edge.
- No stop/start between the two bytes of a 2-byte frame.
- STOP0: o_sclk=0, o_din=0. STOP1: o_sclk=1. STOP2: o_din=1, after which the FSM returns to IDLE.
- Outputs are registered and glitch-free. o_din changes only while o_sclk=0, except the start and stop transitions.

## Timing
- Tick: each state lasts exactly CLK_DIV system clocks. The divider restarts at accept, so ticks are aligned to the request.
- busy, o_din falling (START) and the state change all take effect on the same clock edge as the accept, so they are visible one cycle after valid.
- Frame length:
  - 1-byte frame: 1 + 16 + 3 = 20 ticks.
  - 2-byte frame: 1 + 32 + 3 = 36 ticks.
- busy stays high for exactly (ticks × CLK_DIV) cycles and falls on the same edge where o_din rises at the end of STOP2 (the FSM is back in IDLE with the lines already high).
- A new request may be sampled on the first edge where busy=0. Back-to-back requests therefore have no idle cycle beyond the one valid-sampling edge.
- valid held high continuously restarts a new frame with the latched inputs of that edge each time busy falls.
- CLK_DIV=1: each state lasts one cycle; the behaviour is otherwise identical.

## Configuration
- TM1640_DATACMD_EN defined: every 2-byte frame is preceded by a separate 1-byte frame carrying 8'h44 (fixed-address data command), with full start/stop. Total is 20 + 36 = 56 ticks under one busy period. 1-byte frames are unchanged.
- TM1640_DATACMD_EN undefined: no prefix. The sequencer is responsible for issuing the data command itself.

## Test plan
- Reset: assert RST_N=0 mid-frame -> o_sclk=1, o_din=1, busy=0 asynchronously. After release, the next valid starts a clean frame.
- Command frame: CLK_DIV=12, valid pulse with pos=8'hFF, value=8'h89 -> busy high 240 cycles. Capturing o_din on o_sclk rising edges gives 1,0,0,1,0,0,0,1. Start and stop conditions are present.
- Data frame: pos=8'hC3, value=8'hFB -> busy 432 cycles. Captured bits give 8'hC3 then 8'hFB (LSB first), with no stop between bytes.
- Busy ignore: valid pulses during busy -> no effect on the frame or busy length. A pulse on the first busy=0 edge is accepted.
- Sequencer loop: sixteen requests pos=8'hC0..8'hCF, each issued after busy=0 -> sixteen complete frames in order, none dropped.
- Macro: with TM1640_DATACMD_EN defined, pos=8'hC0, value=8'hFF -> 8'h44 frame then {C0,FF} frame, busy 672 cycles at CLK_DIV=12.

Source files
------------

// File: rtl/tm1640_writer_if.sv
// Request channel between the display sequencer and the TM1640 write engine:
// one command byte or one address/data pair per valid strobe, busy while framing.
interface tm1640_writer_if;
   logic       valid;
   logic [7:0] pos;
   logic [7:0] value;
   logic       busy;

   modport master (output valid, pos, value, input busy);
   modport slave  (input valid, pos, value, output busy);
endinterface

// File: rtl/tm1640_writer.sv
// TM1640 two-wire write engine: start, LSB-first bytes, stop, at CLK_DIV clocks per state.
// Define TM1640_DATACMD_EN to prefix every address/data frame with a 8'h44 command frame.
module tm1640_writer #(
   parameter int unsigned CLK_DIV      = 12,
   parameter logic [7:0]  CMD_ONLY_POS = 8'hFF
) (
   input  logic          CLK,
   input  logic          RST_N,
   tm1640_writer_if.slave req,
   output logic          o_sclk,
   output logic          o_din
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_BITLO, S_BITHI, S_STOP0, S_STOP1, S_STOP2
   } state_t;

   localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   sh_q, sh_d;
   logic [4:0]    left_q, left_d;
   logic          sclk_q, sclk_d;
   logic          din_q, din_d;
   logic          busy_q, busy_d;
   logic          tick;

`ifdef TM1640_DATACMD_EN
   localparam logic [7:0] DATA_CMD = 8'h44;
   logic          pend_q, pend_d;
   logic [15:0]   data_q, data_d;
`endif

   assign tick     = (cnt_q == CNT_MAX);
   assign o_sclk   = sclk_q;
   assign o_din    = din_q;
   assign req.busy = busy_q;

   // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      left_d  = left_q;
      sclk_d  = sclk_q;
      din_d   = din_q;
      busy_d  = busy_q;
`ifdef TM1640_DATACMD_EN
      pend_d  = pend_q;
      data_d  = data_q;
`endif

      if (state_q != S_IDLE) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (req.valid) begin
               state_d = S_START;
               cnt_d   = '0;
               sclk_d  = 1'b1;
               din_d   = 1'b0;
               busy_d  = 1'b1;
               if (req.pos == CMD_ONLY_POS) begin
                  sh_d   = {8'h00, req.value};
                  left_d = 5'd8;
               end else begin
`ifdef TM1640_DATACMD_EN
                  sh_d   = {8'h00, DATA_CMD};
                  left_d = 5'd8;
                  pend_d = 1'b1;
                  data_d = {req.value, req.pos};
`else
                  sh_d   = {req.value, req.pos};
                  left_d = 5'd16;
`endif
               end
            end
         end

         S_START: begin
            if (tick) begin
               state_d = S_BITLO;
               sclk_d  = 1'b0;
               din_d   = sh_q[0];
            end else if (din_q) begin
               // Chained start: the line is still high from the previous stop, drop it now.
               din_d = 1'b0;
            end
         end

         S_BITLO: begin
            if (tick) begin
               state_d = S_BITHI;
               sclk_d  = 1'b1;
            end
         end

         S_BITHI: begin
            if (tick) begin
               sh_d   = sh_q >> 1;
               left_d = left_q - 5'd1;
               sclk_d = 1'b0;
               if (left_q == 5'd1) begin
                  state_d = S_STOP0;
                  din_d   = 1'b0;
               end else begin
                  state_d = S_BITLO;
                  din_d   = sh_q[1];
               end
            end
         end

         S_STOP0: begin
            if (tick) begin
               state_d = S_STOP1;
               sclk_d  = 1'b1;
            end
         end

         S_STOP1: begin
            if (tick) begin
               state_d = S_STOP2;
            end
         end

         S_STOP2: begin
            if (tick) begin
               din_d = 1'b1;
`ifdef TM1640_DATACMD_EN
               if (pend_q) begin
                  state_d = S_START;
                  sh_d    = data_q;
                  left_d  = 5'd16;
                  pend_d  = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end
`else
               state_d = S_IDLE;
               busy_d  = 1'b0;
`endif
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         left_q  <= '0;
         sclk_q  <= 1'b1;
         din_q   <= 1'b1;
         busy_q  <= 1'b0;
`ifdef TM1640_DATACMD_EN
         pend_q  <= 1'b0;
         data_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         left_q  <= left_d;
         sclk_q  <= sclk_d;
         din_q   <= din_d;
         busy_q  <= busy_d;
`ifdef TM1640_DATACMD_EN
         pend_q  <= pend_d;
         data_q  <= data_d;
`endif
      end
   end

endmodule

// File: tb/tb_tm1640_writer.sv
// Directed bench for tm1640_writer: decodes the two-wire bus and checks frames, busy length and reset.
module tb_tm1640_writer;

   localparam int DIV = 12;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic o_sclk, o_din;
   int   n_cmp = 0;
   int   n_bad = 0;

   tm1640_writer_if req ();

   tm1640_writer #(.CLK_DIV(DIV), .CMD_ONLY_POS(8'hFF)) dut (
      .CLK    (clk),
      .RST_N  (rst_n),
      .req    (req.slave),
      .o_sclk (o_sclk),
      .o_din  (o_din)
   );

   always #5 clk = ~clk;

   // Bus monitor: start/stop conditions and the data line at every sclk rising edge.
   logic ps = 1'b1;
   logic pd = 1'b1;
   int   n_start = 0;
   int   n_stop  = 0;
   bit   bits[$];

   always @(negedge clk) begin
      if (o_sclk && ps && pd && !o_din) n_start <= n_start + 1;
      if (o_sclk && ps && !pd && o_din) n_stop <= n_stop + 1;
      if (o_sclk && !ps) bits.push_back(o_din);
      ps <= o_sclk;
      pd <= o_din;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] get_byte(input int at);
      logic [7:0] b = '0;
      for (int i = 0; i < 8; i++) b[i] = bits[at + i];
      return b;
   endfunction

   // Called at a negedge with busy low; returns at a negedge (+1) with busy low again.
   task automatic run_frame(input string tag, input logic [7:0] p, input logic [7:0] v,
                            input bit noise);
      int  b0, s0, t0, len, ticks, n_edges, exp_edges, off, n_frames;
      bit  two, pre, done;
      two = (p != 8'hFF);
`ifdef TM1640_DATACMD_EN
      pre = two;
`else
      pre = 1'b0;
`endif
      ticks     = two ? 36 : 20;
      exp_edges = two ? 17 : 9;
      n_frames  = 1;
      if (pre) begin
         ticks     += 20;
         exp_edges += 9;
         n_frames   = 2;
      end
      b0 = bits.size();
      s0 = n_start;
      t0 = n_stop;

      req.valid = 1'b1;
      req.pos   = p;
      req.value = v;
      @(posedge clk);
      #1;
      check($sformatf("%s/accept_busy", tag), req.busy, 1);
      check($sformatf("%s/start_lines", tag), {o_sclk, o_din}, 2'b10);
      req.valid = 1'b0;

      len  = 0;
      done = 1'b0;
      for (int k = 0; k < 2000 && !done; k++) begin
         @(negedge clk);
         if (!req.busy) begin
            done = 1'b1;
         end else begin
            len++;
            req.valid = noise && (len % 50 == 10);
            req.pos   = 8'h12;
            req.value = 8'h34;
         end
      end
      req.valid = 1'b0;
      #1;
      check($sformatf("%s/busy_timeout", tag), done, 1);
      check($sformatf("%s/busy_len", tag), len, ticks * DIV);
      check($sformatf("%s/idle_lines", tag), {o_sclk, o_din}, 2'b11);
      check($sformatf("%s/starts", tag), n_start - s0, n_frames);
      check($sformatf("%s/stops", tag), n_stop - t0, n_frames);

      n_edges = bits.size() - b0;
      check($sformatf("%s/sclk_edges", tag), n_edges, exp_edges);
      if (n_edges == exp_edges) begin
         off = b0;
         if (pre) begin
            check($sformatf("%s/prefix_cmd", tag), get_byte(off), 8'h44);
            off += 9;
         end
         if (two) begin
            check($sformatf("%s/byte_pos", tag), get_byte(off), p);
            check($sformatf("%s/byte_val", tag), get_byte(off + 8), v);
            check($sformatf("%s/stop_bit", tag), bits[off + 16], 0);
         end else begin
            check($sformatf("%s/byte_cmd", tag), get_byte(off), v);
            check($sformatf("%s/stop_bit", tag), bits[off + 8], 0);
         end
      end
   endtask

   initial begin
      req.valid = 1'b0;
      req.pos   = 8'h00;
      req.value = 8'h00;

      // Reset values while held in reset.
      repeat (3) @(negedge clk);
      check("rst/sclk", o_sclk, 1);
      check("rst/din", o_din, 1);
      check("rst/busy", req.busy, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;

      // Command frame 0x89: bits 1,0,0,1,0,0,0,1 LSB first.
      run_frame("cmd89", 8'hFF, 8'h89, 1'b0);
      // Address/data frame, no stop between bytes.
      run_frame("dataC3", 8'hC3, 8'hFB, 1'b0);
      // Requests during busy are ignored; the first busy=0 edge accepts the next one.
      run_frame("noise", 8'hFF, 8'h89, 1'b1);
      run_frame("b2b", 8'hC1, 8'h5A, 1'b0);

      // Reset mid-frame forces both lines high and busy low without a clock edge.
      req.valid = 1'b1;
      req.pos   = 8'hC2;
      req.value = 8'h0F;
      @(posedge clk);
      #1;
      req.valid = 1'b0;
      repeat (50) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst/sclk", o_sclk, 1);
      check("midrst/din", o_din, 1);
      check("midrst/busy", req.busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      run_frame("after_rst", 8'hFF, 8'h40, 1'b0);

      // Sequencer sweep across all sixteen grid addresses.
      for (int i = 0; i < 16; i++) begin
         run_frame($sformatf("seq%0d", i), 8'hC0 + 8'(i), 8'(i * 17 + 3), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
